regfile_write_arbiter: RTL



---
 rtl/regfile_ctrl_pkg.sv | 15 +
 rtl/rf_clear_seq.sv | 39 +++
 rtl/regfile_write_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared types and sizes for the register-file write path.
// Holds the arbiter state enum and register-file geometry constants.
package regfile_ctrl_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int RF_ADDR_W    = 4;
    localparam int RF_DATA_W    = 16;
    localparam int RF_NUM_REGS  = 16;
    localparam int RF_ZERO_ADDR = 0;

endpackage

// File: rtl/rf_clear_seq.sv
// Zero-fill address sequencer: walks 0..NUM_REGS-1, one address per cycle.
// Ports: clk, rst (async high), start pulse in; busy, done (last address), cnt out.
module rf_clear_seq
    import regfile_ctrl_pkg::*;
#(
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_REGS = RF_NUM_REGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cnt
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

    assign done = busy && (cnt == LAST);

    // Comes out of reset already busy so the file is scrubbed at power-up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b1;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
        end else if (busy) begin
            if (done) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port: arbitrates WB vs multi-cycle writes, runs zero-fill.
// Ports: clk, rst, clr_req/clr_busy, wb_*/mc_* valid-ready requesters, rf_load/rf_caddr/rf_c, grant_mc.
// Option: REGFILE_ARB_STARVE_GUARD_EN forces one mc write after STARVE_MAX denied cycles.
module regfile_write_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int DATA_W     = RF_DATA_W,
    parameter int ADDR_W     = RF_ADDR_W,
    parameter int NUM_REGS   = RF_NUM_REGS,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              clr_busy,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_ready,
    input  logic              mc_valid,
    input  logic [ADDR_W-1:0] mc_addr,
    input  logic [DATA_W-1:0] mc_data,
    output logic              mc_ready,
    output logic              rf_load,
    output logic [ADDR_W-1:0] rf_caddr,
    output logic [DATA_W-1:0] rf_c,
    output logic              grant_mc
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_ADDR);

    if (STARVE_MAX < 1) begin : g_bad_starve
        $error("STARVE_MAX must be at least 1");
    end

    state_t            state_q;
    state_t            state_d;
    logic              seq_start;
    logic              seq_done;
    logic [ADDR_W-1:0] seq_cnt;
    logic              wb_acc;
    logic              mc_acc;
    logic              in_run;

    assign in_run    = (state_q == RUN);
    assign seq_start = in_run && clr_req;
    assign wb_acc    = wb_valid && wb_ready;
    assign mc_acc    = mc_valid && mc_ready;

    rf_clear_seq #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_clear_seq (
        .clk   (clk),
        .rst   (rst),
        .start (seq_start),
        .busy  (clr_busy),
        .done  (seq_done),
        .cnt   (seq_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= CLEAR;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CLEAR: if (seq_done) state_d = RUN;
            RUN:   if (clr_req)  state_d = CLEAR;
        endcase
    end

`ifdef REGFILE_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic [SW-1:0] starve_q;
    logic          force_mc;

    // Only counts while mc is actually waiting; it saturates at SMAX
    // because that cycle always grants mc.
    assign force_mc = in_run && (starve_q == SMAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else if (in_run) begin
            if (clr_req)       starve_q <= '0;
            else if (mc_acc)   starve_q <= '0;
            else if (mc_valid) starve_q <= starve_q + 1'b1;
        end
    end

    always_comb begin
        wb_ready = 1'b0;
        mc_ready = 1'b0;
        if (force_mc) begin
            mc_ready = 1'b1;
        end else if (in_run) begin
            wb_ready = 1'b1;
            mc_ready = ~wb_valid;
        end
    end
`else
    always_comb begin
        wb_ready = 1'b0;
        mc_ready = 1'b0;
        if (in_run) begin
            wb_ready = 1'b1;
            mc_ready = ~wb_valid;
        end
    end
`endif

    // Writes to register 0 are accepted but never reach the file; the
    // address/data outputs keep their last real write in that case.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_load  <= 1'b0;
            rf_caddr <= '0;
            rf_c     <= '0;
            grant_mc <= 1'b0;
        end else if (!in_run) begin
            rf_load  <= 1'b1;
            rf_caddr <= seq_cnt;
            rf_c     <= '0;
        end else if (wb_acc) begin
            rf_load  <= (wb_addr != ZERO_ADDR);
            grant_mc <= 1'b0;
            if (wb_addr != ZERO_ADDR) begin
                rf_caddr <= wb_addr;
                rf_c     <= wb_data;
            end
        end else if (mc_acc) begin
            rf_load  <= (mc_addr != ZERO_ADDR);
            grant_mc <= 1'b1;
            if (mc_addr != ZERO_ADDR) begin
                rf_caddr <= mc_addr;
                rf_c     <= mc_data;
            end
        end else begin
            rf_load <= 1'b0;
        end
    end

endmodule
